// File: rtl/ring_decoder_pkg.sv
// Shared definitions for the ring_decoder block: FSM state encoding and default ring width.
package ring_decoder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam int N_DEFAULT = 4;

endpackage

// File: rtl/ring_decoder_onehot_to_bin.sv
// Combinational one-hot to binary converter with a legality flag.
// Reusable by any consumer of a ring-counter code.
module onehot_to_bin #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] ring,
  output logic [W-1:0] idx,
  output logic         legal
);

  // Exactly one bit set: non-zero, and clearing the lowest set bit leaves nothing.
  always_comb begin
    legal = (ring != {N{1'b0}}) &&
            ((ring & (ring - {{(N-1){1'b0}}, 1'b1})) == {N{1'b0}});
  end

  // Priority encode; the result only matters when legal is high.
  always_comb begin
    idx = {W{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (ring[i]) begin
        idx = W'(i);
      end else begin
        idx = idx;
      end
    end
  end

endmodule

// File: rtl/ring_decoder.sv
// Decodes a sampled one-hot ring code to a position, tracks direction and
// revolutions, and latches a sticky error on illegal codes or jumps.
module ring_decoder
  import ring_decoder_pkg::*;
#(
  parameter int N = N_DEFAULT,
  parameter int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         init,
  input  logic         en,
  input  logic [N-1:0] ring,
  output logic [W-1:0] pos,
  output logic         dir,
  output logic         step,
  output logic         locked,
  output logic         err,
  output logic [7:0]   rev
);

  localparam logic [W:0]   N_EXT  = (W+1)'(N);
  localparam logic [W:0]   D_ONE  = (W+1)'(1);
  localparam logic [W:0]   D_BACK = (W+1)'(N - 1);
  localparam logic [W:0]   D_ZERO = (W+1)'(0);
  localparam logic [W-1:0] LAST   = W'(N - 1);
  localparam logic [W-1:0] FIRST  = W'(0);

  logic [W-1:0] idx;
  logic         legal;
  logic [W:0]   delta_raw;
  logic [W:0]   delta;

  state_t       state;
  state_t       state_nxt;
  logic [W-1:0] pos_nxt;
  logic         dir_nxt;
  logic         step_nxt;
  logic         locked_nxt;
  logic         err_nxt;
  logic [7:0]   rev_nxt;

  onehot_to_bin #(.N(N), .W(W)) u_decode (
    .ring  (ring),
    .idx   (idx),
    .legal (legal)
  );

  // (idx - pos) mod N; adding N first keeps the difference non-negative for any N.
  always_comb begin
    delta_raw = {1'b0, idx} + N_EXT - {1'b0, pos};
    if (delta_raw >= N_EXT) begin
      delta = delta_raw - N_EXT;
    end else begin
      delta = delta_raw;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    dir_nxt   = dir;
    step_nxt  = 1'b0;
    rev_nxt   = rev;
    case (state)
      IDLE: begin
        if (en) begin
          if (legal) begin
            state_nxt = TRACK;
            pos_nxt   = idx;
          end else begin
            state_nxt = FAULT;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      TRACK: begin
        if (!en) begin
          state_nxt = TRACK;
        end else if (!legal) begin
          state_nxt = FAULT;
        end else if (delta == D_ZERO) begin
          state_nxt = TRACK;
        end else if (delta == D_ONE) begin
          pos_nxt  = idx;
          dir_nxt  = 1'b1;
          step_nxt = 1'b1;
          if ((pos == LAST) && (idx == FIRST)) begin
            rev_nxt = rev + 8'd1;
          end else begin
            rev_nxt = rev;
          end
        end else if (delta == D_BACK) begin
          pos_nxt  = idx;
          dir_nxt  = 1'b0;
          step_nxt = 1'b1;
          if ((pos == FIRST) && (idx == LAST)) begin
            rev_nxt = rev - 8'd1;
          end else begin
            rev_nxt = rev;
          end
        end else begin
          state_nxt = FAULT;
        end
      end
      FAULT: begin
        state_nxt = FAULT;
      end
      default: begin
        // Unreachable encoding: treat as a fault rather than silently recover.
        state_nxt = FAULT;
      end
    endcase
    locked_nxt = (state_nxt == TRACK);
    err_nxt    = err | (state_nxt == FAULT);
  end

  // State and output registers with synchronous init.
  always_ff @(posedge clk) begin
    if (init) begin
      state  <= IDLE;
      pos    <= {W{1'b0}};
      dir    <= 1'b0;
      step   <= 1'b0;
      locked <= 1'b0;
      err    <= 1'b0;
      rev    <= 8'd0;
    end else begin
      state  <= state_nxt;
      pos    <= pos_nxt;
      dir    <= dir_nxt;
      step   <= step_nxt;
      locked <= locked_nxt;
      err    <= err_nxt;
      rev    <= rev_nxt;
    end
  end

endmodule

// File: tb/tb_ring_decoder.sv
// Scoreboard bench for ring_decoder (N=4): directed scenarios then random traffic,
// checked against a behavioural model of the decoding rules.
module tb_ring_decoder;

  localparam int N = 4;
  localparam int W = 2;

  logic         clk;
  logic         init;
  logic         en;
  logic [N-1:0] ring;
  logic [W-1:0] pos;
  logic         dir;
  logic         step;
  logic         locked;
  logic         err;
  logic [7:0]   rev;

  typedef struct packed {
    logic [W-1:0] pos;
    logic         dir;
    logic         step;
    logic         locked;
    logic         err;
    logic [7:0]   rev;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: mode 0 = idle, 1 = tracking, 2 = fault.
  int m_mode = 0;
  int m_pos  = 0;
  int m_dir  = 0;
  int m_rev  = 0;
  int m_err  = 0;

  ring_decoder #(.N(N)) dut (
    .clk    (clk),
    .init   (init),
    .en     (en),
    .ring   (ring),
    .pos    (pos),
    .dir    (dir),
    .step   (step),
    .locked (locked),
    .err    (err),
    .rev    (rev)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int find_idx(input logic [N-1:0] r);
    int k;
    k = 0;
    for (int b = 0; b < N; b++) if (r[b]) k = b;
    return k;
  endfunction

  // Apply one cycle of stimulus and push the model's prediction for the following edge.
  task automatic issue(input bit i, input bit e, input logic [N-1:0] r);
    exp_t x;
    int   s;
    int   k;
    int   d;
    @(negedge clk);
    init = i;
    en   = e;
    ring = r;
    s    = 0;
    if (i) begin
      m_mode = 0; m_pos = 0; m_dir = 0; m_rev = 0; m_err = 0;
    end else if (e && m_mode != 2) begin
      if ($countones(r) != 1) begin
        m_mode = 2; m_err = 1;
      end else begin
        k = find_idx(r);
        if (m_mode == 0) begin
          m_mode = 1; m_pos = k;
        end else begin
          d = (k - m_pos + N) % N;
          if (d == 1) begin
            if (m_pos == N - 1) m_rev = (m_rev + 1) % 256;
            m_pos = k; m_dir = 1; s = 1;
          end else if (d == N - 1) begin
            if (m_pos == 0) m_rev = (m_rev + 255) % 256;
            m_pos = k; m_dir = 0; s = 1;
          end else if (d != 0) begin
            m_mode = 2; m_err = 1;
          end
        end
      end
    end
    x.pos    = W'(m_pos);
    x.dir    = m_dir[0];
    x.step   = s[0];
    x.locked = (m_mode == 1);
    x.err    = m_err[0];
    x.rev    = 8'(m_rev);
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle after an issued edge; pop and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pos",    int'(pos),    int'(e.pos));
      chk("dir",    int'(dir),    int'(e.dir));
      chk("step",   int'(step),   int'(e.step));
      chk("locked", int'(locked), int'(e.locked));
      chk("err",    int'(err),    int'(e.err));
      chk("rev",    int'(rev),    int'(e.rev));
    end
  end

  initial begin
    int r;
    logic [N-1:0] code;
    init = 1'b0;
    en   = 1'b0;
    ring = 4'b0000;

    // Left rotation with wrap: rev must reach 1.
    issue(1'b1, 1'b0, 4'b0000);
    issue(1'b0, 1'b1, 4'b0001);
    issue(1'b0, 1'b1, 4'b0010);
    issue(1'b0, 1'b1, 4'b0100);
    issue(1'b0, 1'b1, 4'b1000);
    issue(1'b0, 1'b1, 4'b0001);
    @(posedge clk); #2;
    chk("left_rev_const", int'(rev), 1);
    chk("left_pos_const", int'(pos), 0);

    // Right rotation with underflow to 255.
    issue(1'b1, 1'b0, 4'b0000);
    issue(1'b0, 1'b1, 4'b0001);
    issue(1'b0, 1'b1, 4'b1000);
    @(posedge clk); #2;
    chk("right_rev_const", int'(rev), 255);
    issue(1'b0, 1'b1, 4'b0100);
    issue(1'b0, 1'b1, 4'b0010);
    issue(1'b0, 1'b1, 4'b0001);

    // Hold and gating.
    issue(1'b1, 1'b0, 4'b0000);
    issue(1'b0, 1'b1, 4'b0010);
    issue(1'b0, 1'b1, 4'b0010);
    issue(1'b0, 1'b0, 4'b0100);

    // Illegal code, then FAULT is absorbing.
    issue(1'b1, 1'b0, 4'b0000);
    issue(1'b0, 1'b1, 4'b0001);
    issue(1'b0, 1'b1, 4'b0011);
    issue(1'b0, 1'b1, 4'b0010);
    @(posedge clk); #2;
    chk("fault_locked_const", int'(locked), 0);
    chk("fault_err_const", int'(err), 1);

    // Illegal jump of two positions.
    issue(1'b1, 1'b0, 4'b0000);
    issue(1'b0, 1'b1, 4'b0001);
    issue(1'b0, 1'b1, 4'b0100);

    // Reset mid-run with en high, then relock without a step.
    issue(1'b1, 1'b0, 4'b0000);
    issue(1'b0, 1'b1, 4'b1000);
    issue(1'b0, 1'b1, 4'b0001);
    issue(1'b0, 1'b1, 4'b0010);
    issue(1'b0, 1'b1, 4'b0100);
    issue(1'b1, 1'b1, 4'b1000);
    issue(1'b0, 1'b1, 4'b1000);
    @(posedge clk); #2;
    chk("relock_pos_const", int'(pos), 3);
    chk("relock_step_const", int'(step), 0);

    // Random traffic: mostly adjacent moves, some holds, illegal codes and inits.
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        issue(1'b1, $urandom_range(0, 1) == 1, 4'(1 << $urandom_range(0, N - 1)));
      end else begin
        if (r < 40)      code = 4'(1 << ((m_pos + 1) % N));
        else if (r < 75) code = 4'(1 << ((m_pos + N - 1) % N));
        else if (r < 85) code = 4'(1 << m_pos);
        else if (r < 92) code = 4'(1 << ((m_pos + 2) % N));
        else             code = 4'($urandom_range(0, 15));
        issue(1'b0, $urandom_range(0, 9) != 0, code);
      end
    end

    for (int t = 0; t < 10 && exp_q.size() > 0; t++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d left, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
